mil_rx_word: RTL
================

Name: mil_rx_word

Overview:
- Parametrised MIL-STD-1553 Manchester-II word receiver; next generation of the bus receive front end.
- Takes the differential bus comparator outputs in_p/in_n.
- Detects command/status and data syncs, recovers DATA_W bits plus odd parity with mid-bit resynchronisation, and flags Manchester, parity and overrun errors.
- Presents each good word on a valid/ready handshake to the protocol/RT controller.

Parameters:
- HALF_BIT, 25: clk cycles per half bit (50 MHz clk, 1 Mbit/s).
- DATA_W, 16: data bits per word, MSB first.
- SYNC_TOL, 3: allowed ± deviation in clocks for the sync mid-edge and for data mid-bit edges.
- SYNC_HB, 3: sync half-length in half bits (1.5 bit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_p  in  1  positive bus comparator, asynchronous.
- in_n  in  1  negative bus comparator, asynchronous.
- rx_en  in  1  receiver enable.
- word_data  out  DATA_W  received data, held while word_valid.
- word_cw  out  1  1 = command/status sync, 0 = data sync.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts the word.
- err_manch  out  1  one-cycle pulse: Manchester violation mid-word.
- err_parity  out  1  one-cycle pulse: odd-parity failure.
- err_overrun  out  1  one-cycle pulse: word completed while previous word unaccepted.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Inputs pass through a 2-FF synchroniser. Line decode: HI = p&!n, LO = n&!p, NUL = otherwise.
- States:
  - IDLE: wait for HI or LO with rx_en=1; start run counter cnt=1, latch first polarity → SYNC1.
  - SYNC1: cnt++ while the line holds. On an opposite-polarity edge with cnt in [SYNC_HB*HALF_BIT-SYNC_TOL, SYNC_HB*HALF_BIT+SYNC_TOL] → SYNC2 with cnt=1. HI-first sets word_cw=1 internally; LO-first sets it to 0. Any other edge, NUL, or cnt>SYNC_HB*HALF_BIT+SYNC_TOL → IDLE, no error pulse.
  - SYNC2: line must stay at the second polarity until cnt reaches SYNC_HB*HALF_BIT-SYNC_TOL, else → IDLE with no error. At cnt==SYNC_HB*HALF_BIT → DATA with bit counter 0, phase counter 0.
  - DATA: receives DATA_W+1 bits (data then parity). Sample half A at phase HALF_BIT/2 and half B at phase HALF_BIT+HALF_BIT/2.
    - A==B, or NUL at either sample → err_manch pulse, → IDLE.
    - Bit value = (A==HI). Data bits shift in MSB first.
    - Resync: a line edge at phase in [HALF_BIT-SYNC_TOL, HALF_BIT+SYNC_TOL] forces phase=HALF_BIT on the next clock.
    - Phase wraps at 2*HALF_BIT-1 → 0; the bit counter advances on wrap.
  - After the parity half-B sample, evaluate the XOR of the DATA_W+1 bits:
    - XOR==0 → err_parity pulse, word dropped.
    - Otherwise, if word_valid=1 and word_ready=0 → err_overrun pulse; the new word is dropped and the old one is kept.
    - Otherwise word_data/word_cw load and word_valid=1 on the next clock. Latency from parity half-B sample to word_valid is 1 clk.
  - After evaluation, state → IDLE.
- Handshake:
  - word_valid clears on the clock where word_valid&word_ready.
  - Acceptance and a new word completing on the same clock: the old word is consumed, the new word loads, word_valid stays 1, no overrun.
- rx_en=0 in any state → IDLE next clock; the partial word is discarded without error. word_valid and word_data are unaffected.
- Back-to-back words with no gap: the state returns to IDLE on the clock after the parity sample. The sync start is detected from the current line level, because IDLE accepts a line already HI or LO and counts cnt from the evaluation clock. The SYNC_TOL lower bound is sized to absorb this.
- Simultaneous error pulses are impossible: exactly one outcome per word.
- Asynchronous reset mid-word → IDLE immediately; the first new word is only taken after a full sync.

Decomposition:
- Package mil_pkg:
  - state enum {IDLE, SYNC1, SYNC2, DATA}.
  - Line-state enum {NUL, HI, LO}.
  - SYNC_CW/SYNC_DW polarity constants.
  - Helper function sync_len(HALF_BIT, SYNC_HB).
- Sub-module mil_line_decode: 2-FF synchroniser on in_p/in_n plus the line-state and edge-detect outputs. It is shared with a future dual-bus (A/B) receiver.

Test Plan:
- Command sync + 0x1234, parity 0, word_ready=1 → one word_valid pulse, word_data=0x1234, word_cw=1, no error.
- Data sync + 0xFFFF, parity 1, word_ready=0 → word_valid held. A second data word 0x0001, parity 0, then arrives → err_overrun pulse and word_data stays 0xFFFF.
- 0x00A5 with parity bit inverted → err_parity pulse, word_valid stays 0.
- Bit 7 sent as HI/HI (no mid-bit edge) → err_manch pulse, busy falls 1 clk later, no word.
- Clock skew: bits stretched to 52 clk (half bits 26/26) and shortened to 48 clk, word 0xC3C3 → received correctly via resync.
- Sync first half 60 clk (<72) → silent return to IDLE. rx_en dropped at data bit 9 → busy=0 next clk, no pulse. Then a full valid word is received normally.

Source files
------------

// File: rtl/mil_pkg.sv
// Shared types and helpers for the MIL-STD-1553 word receiver.
package mil_pkg;

    // Receiver control states
    typedef enum logic [1:0] {
        StIdle,
        StSync1,
        StSync2,
        StData
    } rx_state_e;

    // Decoded differential line level
    typedef enum logic [1:0] {
        LineNul,
        LineHi,
        LineLo
    } line_e;

    // First-half polarity of the two sync types
    localparam line_e SYNC_CW = LineHi;
    localparam line_e SYNC_DW = LineLo;

    // Length of one sync half in clocks
    function automatic int unsigned sync_len(input int unsigned half_bit,
                                             input int unsigned sync_hb);
        return half_bit * sync_hb;
    endfunction

    // Map comparator pair onto a line level; both or neither asserted is NUL
    function automatic line_e decode_line(input logic p, input logic n);
        if (p && !n) begin
            return LineHi;
        end
        if (n && !p) begin
            return LineLo;
        end
        return LineNul;
    endfunction

endpackage

// File: rtl/mil_line_decode.sv
// Bus comparator front end: 2-FF synchroniser, line decode and edge detect.
module mil_line_decode
    import mil_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_p,
    input  logic  in_n,
    output line_e line,
    output logic  line_edge
);

    logic [1:0] p_sync_q;
    logic [1:0] n_sync_q;
    line_e      line_q;

    // Synchronise the asynchronous comparator outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync_q <= 2'b00;
            n_sync_q <= 2'b00;
        end else begin
            p_sync_q <= {p_sync_q[0], in_p};
            n_sync_q <= {n_sync_q[0], in_n};
        end
    end

    assign line = decode_line(p_sync_q[1], n_sync_q[1]);

    // Previous line level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= LineNul;
        end else begin
            line_q <= line;
        end
    end

    assign line_edge = (line != line_q);

endmodule

// File: rtl/mil_rx_word.sv
// MIL-STD-1553 Manchester-II word receiver with valid/ready word output.
module mil_rx_word
    import mil_pkg::*;
#(
    parameter int unsigned HALF_BIT = 25,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SYNC_TOL = 3,
    parameter int unsigned SYNC_HB  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_p,
    input  logic              in_n,
    input  logic              rx_en,
    output logic [DATA_W-1:0] word_data,
    output logic              word_cw,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              err_manch,
    output logic              err_parity,
    output logic              err_overrun,
    output logic              busy
);

    localparam int unsigned SyncLen = sync_len(HALF_BIT, SYNC_HB);
    localparam int unsigned SyncMin = SyncLen - SYNC_TOL;
    localparam int unsigned SyncMax = SyncLen + SYNC_TOL;
    localparam int unsigned BitLen  = 2 * HALF_BIT;
    localparam int unsigned CntW    = $clog2(SyncMax + 1);
    localparam int unsigned PhaseW  = $clog2(BitLen);
    localparam int unsigned BitW    = $clog2(DATA_W + 1);

    localparam logic [CntW-1:0]   CntMin    = CntW'(SyncMin);
    localparam logic [CntW-1:0]   CntLen    = CntW'(SyncLen);
    localparam logic [CntW-1:0]   CntMax    = CntW'(SyncMax);
    localparam logic [PhaseW-1:0] PhaseA    = PhaseW'(HALF_BIT / 2);
    localparam logic [PhaseW-1:0] PhaseB    = PhaseW'(HALF_BIT + HALF_BIT / 2);
    localparam logic [PhaseW-1:0] PhaseMid  = PhaseW'(HALF_BIT);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BitLen - 1);
    localparam logic [PhaseW-1:0] ResyncLo  = PhaseW'(HALF_BIT - SYNC_TOL);
    localparam logic [PhaseW-1:0] ResyncHi  = PhaseW'(HALF_BIT + SYNC_TOL);
    localparam logic [BitW-1:0]   LastBit   = BitW'(DATA_W);

    line_e line;
    logic  line_edge;

    mil_line_decode u_line_decode (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_p     (in_p),
        .in_n     (in_n),
        .line     (line),
        .line_edge(line_edge)
    );

    rx_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    line_e             pol_q, pol_d;
    logic              cw_q, cw_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [BitW-1:0]   bit_q, bit_d;
    line_e             half_a_q, half_a_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic              word_load;
    logic              err_manch_d, err_parity_d, err_overrun_d;
    logic              bit_val;
    logic              parity_odd;

    logic [DATA_W-1:0] word_data_q;
    logic              word_cw_q, word_valid_q;
    logic              err_manch_q, err_parity_q, err_overrun_q;

    // The current bit is 1 when its first half was HI; parity covers data plus this bit
    assign bit_val    = (half_a_q == LineHi);
    assign parity_odd = ^{shreg_q, bit_val};

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pol_q    <= LineNul;
            cw_q     <= 1'b0;
            phase_q  <= '0;
            bit_q    <= '0;
            half_a_q <= LineNul;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pol_q    <= pol_d;
            cw_q     <= cw_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            half_a_q <= half_a_d;
            shreg_q  <= shreg_d;
        end
    end

    // Next-state: sync qualification, bit sampling with mid-bit resync, word outcome
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pol_d         = pol_q;
        cw_d          = cw_q;
        phase_d       = phase_q;
        bit_d         = bit_q;
        half_a_d      = half_a_q;
        shreg_d       = shreg_q;
        word_load     = 1'b0;
        err_manch_d   = 1'b0;
        err_parity_d  = 1'b0;
        err_overrun_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A line already driven counts as the first sync clock
                if (rx_en && line != LineNul) begin
                    cnt_d   = CntW'(1);
                    pol_d   = line;
                    cw_d    = (line == SYNC_CW);
                    state_d = StSync1;
                end
            end

            StSync1: begin
                if (line == pol_q) begin
                    if (cnt_q == CntMax) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (line != LineNul && cnt_q >= CntMin && cnt_q <= CntMax) begin
                    cnt_d   = CntW'(1);
                    pol_d   = line;
                    state_d = StSync2;
                end else begin
                    state_d = StIdle;
                end
            end

            StSync2: begin
                // Edges are tolerated near the end: the first data bit may start early
                if (line != pol_q && cnt_q < CntMin) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLen) begin
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    bit_d   = bit_q + BitW'(1);
                end else begin
                    phase_d = phase_q + PhaseW'(1);
                end

                // Re-centre on the guaranteed mid-bit transition
                if (line_edge && phase_q >= ResyncLo && phase_q <= ResyncHi) begin
                    phase_d = PhaseMid;
                end

                if (phase_q == PhaseA) begin
                    half_a_d = line;
                end

                if (phase_q == PhaseB) begin
                    if (half_a_q == LineNul || line == LineNul || half_a_q == line) begin
                        err_manch_d = 1'b1;
                        state_d     = StIdle;
                    end else if (bit_q == LastBit) begin
                        state_d = StIdle;
                        if (!parity_odd) begin
                            err_parity_d = 1'b1;
                        end else if (word_valid_q && !word_ready) begin
                            err_overrun_d = 1'b1;
                        end else begin
                            word_load = 1'b1;
                        end
                    end else begin
                        shreg_d = DATA_W'({shreg_q, bit_val});
                    end
                end
            end
        endcase

        // Disabling the receiver discards any partial word silently
        if (!rx_en) begin
            state_d       = StIdle;
            word_load     = 1'b0;
            err_manch_d   = 1'b0;
            err_parity_d  = 1'b0;
            err_overrun_d = 1'b0;
        end
    end

    // Output word holding register and valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data_q  <= '0;
            word_cw_q    <= 1'b0;
            word_valid_q <= 1'b0;
        end else if (word_load) begin
            word_data_q  <= shreg_q;
            word_cw_q    <= cw_q;
            word_valid_q <= 1'b1;
        end else if (word_valid_q && word_ready) begin
            word_valid_q <= 1'b0;
        end
    end

    // Registered one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_manch_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            err_manch_q   <= err_manch_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_cw     = word_cw_q;
    assign word_valid  = word_valid_q;
    assign err_manch   = err_manch_q;
    assign err_parity  = err_parity_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != StIdle);

endmodule
